// File: rtl/leiwand_rv32_bus_master_if.sv
// cyc/stb/stall/ack word bus between the RV32 load/store initiator and its memory responders.
interface leiwand_rv32_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  o_cyc;
  logic                  o_stb;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [31:0]           o_dat;
  logic [2:0]            o_dat_wr_size;
  logic [31:0]           i_dat;
  logic                  i_ack;
  logic                  i_stall;

  modport master (
    output o_cyc, o_stb, o_we, o_addr, o_dat, o_dat_wr_size,
    input  i_dat, i_ack, i_stall
  );

  modport slave (
    input  o_cyc, o_stb, o_we, o_addr, o_dat, o_dat_wr_size,
    output i_dat, i_ack, i_stall
  );
endinterface

// File: rtl/leiwand_rv32_bus_master.sv
// Single-transaction load/store bus initiator: alignment check, strobe-then-release
// handshake with ack timeout, and lane-aligned sign/zero extension of load data.
module leiwand_rv32_bus_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_dat,
  input  logic [2:0]            i_req_size,
  input  logic                  i_req_unsigned,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdat,
  leiwand_rv32_bus_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic [31:0]           word_q, word_n;
  logic                  flag_q, flag_n;
  logic                  uns_q, uns_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           dat_q, dat_n;
  logic [2:0]            size_q, size_n;
  logic                  cyc_q, cyc_n;
  logic                  stb_q, stb_n;
  logic                  busy_n, done_n, err_n;
  logic [31:0]           rdat_n;

  logic [2:0]            req_size;
  logic                  misaligned;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_ext;

  assign bus.o_cyc         = cyc_q;
  assign bus.o_stb         = stb_q;
  assign bus.o_we          = we_q;
  assign bus.o_addr        = addr_q;
  assign bus.o_dat         = dat_q;
  assign bus.o_dat_wr_size = size_q;

  always_comb begin
    req_size = 3'd4;
    if (i_req_size == 3'd1)      req_size = 3'd1;
    else if (i_req_size == 3'd2) req_size = 3'd2;
    misaligned = ((req_size == 3'd2) && i_req_addr[0]) ||
                 ((req_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
  end

  always_comb begin
    lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      3'd1:    load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      3'd2:    load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = word_q;
    endcase
  end

  // Outputs are computed as next-state values so that every port leaves a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word_q;
    flag_n  = flag_q;
    uns_n   = uns_q;
    we_n    = we_q;
    addr_n  = addr_q;
    dat_n   = dat_q;
    size_n  = size_q;
    cyc_n   = cyc_q;
    stb_n   = stb_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rdat_n  = '0;

    case (state)
      S_IDLE: begin
        if (i_req) begin
          if (misaligned) begin
            flag_n  = 1'b1;
            state_n = S_RESP;
          end else if (!bus.i_stall) begin
            we_n    = i_req_we;
            addr_n  = i_req_addr;
            dat_n   = i_req_dat;
            size_n  = req_size;
            uns_n   = i_req_unsigned;
            flag_n  = 1'b0;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            state_n = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        stb_n   = 1'b0;
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_ack) begin
          word_n  = bus.i_dat;
          cyc_n   = 1'b0;
          flag_n  = 1'b0;
          state_n = S_RESP;
        end else if (cnt == TO_LAST) begin
          cyc_n   = 1'b0;
          flag_n  = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_RESP: begin
        done_n  = 1'b1;
        err_n   = flag_q;
        rdat_n  = (flag_q || we_q) ? '0 : load_ext;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      word_q <= '0;
      flag_q <= 1'b0;
      uns_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      dat_q  <= '0;
      size_q <= '0;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_rdat <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      word_q <= word_n;
      flag_q <= flag_n;
      uns_q  <= uns_n;
      we_q   <= we_n;
      addr_q <= addr_n;
      dat_q  <= dat_n;
      size_q <= size_n;
      cyc_q  <= cyc_n;
      stb_q  <= stb_n;
      o_busy <= busy_n;
      o_done <= done_n;
      o_err  <= err_n;
      o_rdat <= rdat_n;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_bus_master.sv
// Scoreboard bench for leiwand_rv32_bus_master with a behavioural word-memory responder.
module tb_leiwand_rv32_bus_master;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_we, req_uns;
  logic [31:0] req_addr, req_dat;
  logic [2:0]  req_size;
  logic        busy, done, err;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  leiwand_rv32_bus_master_if #(.ADDR_WIDTH(32)) bus ();

  leiwand_rv32_bus_master #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_req_we      (req_we),
    .i_req_addr    (req_addr),
    .i_req_dat     (req_dat),
    .i_req_size    (req_size),
    .i_req_unsigned(req_uns),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_rdat        (rdat),
    .bus           (bus)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [2:0]  size;
    logic [31:0] rdat;
    logic        err;
    int          lat;
    int          stb_cnt;
    logic        cyc_seen;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Responder: acks one cycle after seeing the released strobe, plus resp_ws wait states.
  logic [31:0] mem [0:63];
  bit          resp_dead = 1'b0;
  int          resp_ws   = 0;

  initial begin
    bit          armed;
    int          wcnt;
    logic [31:0] w;
    logic [1:0]  a;
    armed = 1'b0;
    wcnt  = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.i_ack = 1'b0;
    bus.i_dat = '0;
    forever begin
      @(negedge clk);
      if (bus.i_ack) begin
        bus.i_ack = 1'b0;
      end else if (!bus.o_cyc) begin
        armed = 1'b0;
      end else if (bus.o_stb) begin
        if (!resp_dead) begin
          armed = 1'b1;
          wcnt  = resp_ws;
        end
      end else if (armed) begin
        if (wcnt == 0) begin
          armed     = 1'b0;
          bus.i_ack = 1'b1;
          w         = mem[bus.o_addr[7:2]];
          a         = bus.o_addr[1:0];
          if (bus.o_we) begin
            case (bus.o_dat_wr_size)
              3'd1:    w[{a, 3'b000} +: 8] = bus.o_dat[7:0];
              3'd2:    w[{a[1], 4'b0000} +: 16] = bus.o_dat[15:0];
              default: w = bus.o_dat;
            endcase
            mem[bus.o_addr[7:2]] = w;
          end else begin
            bus.i_dat = w;
          end
        end else begin
          wcnt--;
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz, input logic u, input logic [31:0] er,
                       input logic ee, input int lat, input int stbc, input logic cyc_seen);
    @(negedge clk);
    req      = 1'b1;
    req_we   = we;
    req_addr = a;
    req_dat  = d;
    req_size = sz;
    req_uns  = u;
    sb.push_back('{we, a, d, sz, er, ee, lat, stbc, cyc_seen});
  endtask

  task automatic wait_done(output int e0);
    exp_t e;
    bit   ok;
    bit   unstable;
    bit   cyc_seen;
    int   stb_n;
    ok       = 1'b0;
    unstable = 1'b0;
    cyc_seen = 1'b0;
    stb_n    = 0;
    e0       = cycle;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    e0 = cycle;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.o_stb) stb_n++;
      if (bus.o_cyc) begin
        cyc_seen = 1'b1;
        if (bus.o_addr !== e.addr || bus.o_we !== e.we ||
            bus.o_dat !== e.dat || bus.o_dat_wr_size !== e.size) unstable = 1'b1;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(cycle - e0), 32'(e.lat));
    check("rdat", rdat, e.rdat);
    check("err", {31'd0, err}, {31'd0, e.err});
    check("stb_cycles", 32'(stb_n), 32'(e.stb_cnt));
    check("cyc_seen", {31'd0, cyc_seen}, {31'd0, e.cyc_seen});
    check("bus_stable", {31'd0, unstable}, 32'd0);
    check("cyc_at_done", {31'd0, bus.o_cyc}, 32'd0);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int sc;
    int seen;
    rst         = 1'b1;
    req         = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_dat     = '0;
    req_size    = 3'd4;
    req_uns     = 1'b0;
    bus.i_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cyc", {31'd0, bus.o_cyc}, 32'd0);
    check("rst_stb", {31'd0, bus.o_stb}, 32'd0);
    check("rst_rdat", rdat, 32'd0);
    rst = 1'b0;

    // word store then load
    drive(1'b1, 32'h10, 32'hDEADBEEF, 3'd4, 1'b0, 32'h0, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h10, 32'h0, 3'd4, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1, 1'b1);
    wait_done(e0);

    // sub-word loads from 0x80FF7F01
    drive(1'b1, 32'h20, 32'h80FF7F01, 3'd4, 1'b0, 32'h0, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h23, 32'h0, 3'd1, 1'b0, 32'hFFFFFF80, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h23, 32'h0, 3'd1, 1'b1, 32'h00000080, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h22, 32'h0, 3'd2, 1'b0, 32'hFFFF80FF, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h20, 32'h0, 3'd1, 1'b0, 32'h00000001, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h21, 32'h0, 3'd1, 1'b1, 32'h0000007F, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h20, 32'h0, 3'd2, 1'b1, 32'h00007F01, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h22, 32'h0, 3'd1, 1'b0, 32'hFFFFFFFF, 1'b0, 3, 1, 1'b1);
    wait_done(e0);

    // byte store is right-justified on the bus, responder places the lane
    drive(1'b1, 32'h11, 32'h000000A5, 3'd1, 1'b0, 32'h0, 1'b0, 3, 1, 1'b1);
    wait_done(e0);
    drive(1'b0, 32'h10, 32'h0, 3'd4, 1'b0, 32'hDEADA5EF, 1'b0, 3, 1, 1'b1);
    wait_done(e0);

    // misaligned: no bus cycle
    drive(1'b0, 32'h21, 32'h0, 3'd2, 1'b0, 32'h0, 1'b1, 1, 0, 1'b0);
    wait_done(e0);
    drive(1'b0, 32'h22, 32'h0, 3'd4, 1'b0, 32'h0, 1'b1, 1, 0, 1'b0);
    wait_done(e0);
    drive(1'b1, 32'h13, 32'h12345678, 3'd4, 1'b0, 32'h0, 1'b1, 1, 0, 1'b0);
    wait_done(e0);

    // absent responder, then a live one
    resp_dead = 1'b1;
    drive(1'b0, 32'h10, 32'h0, 3'd4, 1'b0, 32'h0, 1'b1, TIMEOUT + 2, 1, 1'b1);
    wait_done(e0);
    resp_dead = 1'b0;
    drive(1'b0, 32'h10, 32'h0, 3'd4, 1'b0, 32'hDEADA5EF, 1'b0, 3, 1, 1'b1);
    wait_done(e0);

    // two wait states
    resp_ws = 2;
    drive(1'b0, 32'h20, 32'h0, 3'd4, 1'b0, 32'h80FF7F01, 1'b0, 5, 1, 1'b1);
    wait_done(e0);
    resp_ws = 0;

    // stall held for 5 cycles with request pending
    bus.i_stall = 1'b1;
    drive(1'b0, 32'h20, 32'h0, 3'd4, 1'b0, 32'h80FF7F01, 1'b0, 3, 1, 1'b1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || bus.o_stb || bus.o_cyc) seen++;
    end
    check("stall_no_activity", 32'(seen), 32'd0);
    bus.i_stall = 1'b0;
    sc = cycle;
    wait_done(e0);
    check("stall_release_edge", 32'(e0 - sc), 32'd1);

    // reset while waiting for a slow ack
    resp_ws = 20;
    @(negedge clk);
    req      = 1'b1;
    req_we   = 1'b0;
    req_addr = 32'h10;
    req_size = 3'd4;
    req_uns  = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        break;
      end
    end
    req = 1'b0;
    check("rst_txn_accepted", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("wait_cyc_before_rst", {31'd0, bus.o_cyc}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", {31'd0, bus.o_cyc}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_stb", {31'd0, bus.o_stb}, 32'd0);
    check("midrst_addr", bus.o_addr, 32'd0);
    check("midrst_outs", {29'd0, done, err, bus.o_we}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    resp_ws = 0;
    drive(1'b0, 32'h20, 32'h0, 3'd4, 1'b0, 32'h80FF7F01, 1'b0, 3, 1, 1'b1);
    wait_done(e0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
